// File: rtl/riscv_defs.sv
// -----------------------------------------------------------------------------
// riscv_defs
// Shared definitions for the data-memory arbiter.
//   arb_state_t   : arbiter FSM encoding (ARB_IDLE / ARB_RD_WAIT)
//   ARB_STRB_FULL : all four byte lanes enabled (programmer writes full words)
// -----------------------------------------------------------------------------
package riscv_defs;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_RD_WAIT = 1'b1
    } arb_state_t;

    localparam logic [3:0] ARB_STRB_FULL = 4'hF;

endpackage : riscv_defs

// File: rtl/riscv_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// riscv_dmem_arbiter
// Shares the single-port data-memory block RAM between the CPU load/store path
// and the UART programmer write stream. Stalls the single-cycle core while the
// port is taken by the programmer or while a load is in flight.
//
// Configuration macro: ARB_STARVE_GUARD_EN
//   defined   : after MAX_HOLD consecutive programmer grants against a waiting
//               CPU, the CPU wins one grant (hold_cnt fairness counter).
//   undefined : strict programmer priority; no counter, MAX_HOLD unused.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   prog_mode           : programmer owns the system; CPU is never granted
//   cpu_req/we/addr/wdata/wstrb : CPU access (addr is a byte address)
//   cpu_stall           : freeze PC and writeback
//   cpu_rdata/rvalid    : load data and its one-cycle strobe
//   upg_req/addr/wdata  : programmer word write; upg_ack accepts it (comb.)
//   mem_en/we/addr/wdata: macro control; mem_rdata returns one cycle later
//   dbg_state/dbg_hold_cnt : current FSM state and fairness counter
//
// Handshake: a CPU request is complete in the cycle cpu_stall is low (store
// grant, or the RD_WAIT cycle for a load); the CPU holds its request fields
// stable while cpu_stall is high. A programmer write is accepted in every
// cycle where upg_req and upg_ack are both high.
// -----------------------------------------------------------------------------
module riscv_dmem_arbiter
    import riscv_defs::*;
#(
    parameter int ADDR_W   = 14,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_mode,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_wstrb,
    output logic              cpu_stall,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              upg_req,
    input  logic [ADDR_W-1:0] upg_addr,
    input  logic [31:0]       upg_wdata,
    output logic              upg_ack,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output arb_state_t        dbg_state,
    output logic [3:0]        dbg_hold_cnt
);

    arb_state_t state, state_next;
    logic       rd_owner, rd_owner_next;
    logic       cpu_elig;
    logic       upg_win;
    logic       cpu_grant;
    logic       hold_at_max;

    // Only the word-address bits of the CPU byte address reach the macro.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] hold_cnt;

    assign hold_at_max = (hold_cnt == 4'(MAX_HOLD));

    // Counts programmer grants that pushed an eligible CPU request aside.
    // Any CPU grant, a dropped CPU request or programmer mode restarts it.
    always_ff @(posedge clk) begin
        if (rst || prog_mode || !cpu_req || cpu_grant) begin
            hold_cnt <= 4'd0;
        end else if (upg_win && cpu_elig && !hold_at_max) begin
            hold_cnt <= hold_cnt + 4'd1;
        end
    end

    assign dbg_hold_cnt = hold_cnt;
`else
    logic unused_max_hold;
    assign unused_max_hold = ^MAX_HOLD;

    assign hold_at_max  = 1'b0;
    assign dbg_hold_cnt = 4'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            rd_owner <= 1'b0;
        end else begin
            state    <= state_next;
            rd_owner <= rd_owner_next;
        end
    end

    always_comb begin
        state_next    = state;
        rd_owner_next = 1'b0;
        cpu_elig      = 1'b0;
        upg_win       = 1'b0;
        cpu_grant     = 1'b0;
        mem_en        = 1'b0;
        mem_we        = 4'h0;
        mem_addr      = cpu_addr[ADDR_W+1:2];
        mem_wdata     = cpu_wdata;
        upg_ack       = 1'b0;
        cpu_stall     = cpu_req;
        cpu_rvalid    = 1'b0;
        cpu_rdata     = 32'h0;

        // While reset is held nothing is granted, so a read aborted in
        // RD_WAIT never produces its data strobe.
        if (!rst) begin
            cpu_elig  = cpu_req && !prog_mode && (state == ARB_IDLE);
            upg_win   = upg_req && !(cpu_elig && hold_at_max);
            cpu_grant = cpu_elig && !upg_win;

            if (state == ARB_RD_WAIT) begin
                cpu_rvalid = rd_owner;
                cpu_rdata  = rd_owner ? mem_rdata : 32'h0;
                state_next = ARB_IDLE;
            end

            // The port is free during RD_WAIT, so a programmer write can
            // overlap the returning load data.
            if (upg_win) begin
                mem_en    = 1'b1;
                mem_we    = ARB_STRB_FULL;
                mem_addr  = upg_addr;
                mem_wdata = upg_wdata;
                upg_ack   = 1'b1;
            end else if (cpu_grant) begin
                mem_en = 1'b1;
                if (cpu_we) begin
                    mem_we = cpu_wstrb;
                end else begin
                    state_next    = ARB_RD_WAIT;
                    rd_owner_next = 1'b1;
                end
            end

            cpu_stall = cpu_req && !(cpu_grant && cpu_we) && (state != ARB_RD_WAIT);
        end
    end

    assign dbg_state = state;

endmodule : riscv_dmem_arbiter

// File: tb/tb_riscv_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_riscv_dmem_arbiter
// Directed bench for riscv_dmem_arbiter (ADDR_W=14, MAX_HOLD=4). Contains a
// behavioural one-cycle-latency RAM. Inputs change on the falling edge and
// outputs are checked 1 ns later, before the next rising edge.
// -----------------------------------------------------------------------------
module tb_riscv_dmem_arbiter;
    import riscv_defs::*;

`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        prog_mode;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        upg_req;
    logic [13:0] upg_addr;
    logic [31:0] upg_wdata;
    logic        upg_ack;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    arb_state_t  dbg_state;
    logic [3:0]  dbg_hold_cnt;

    int n_vec;
    int n_bad;

    riscv_dmem_arbiter #(.ADDR_W(14), .MAX_HOLD(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .prog_mode    (prog_mode),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_wstrb    (cpu_wstrb),
        .cpu_stall    (cpu_stall),
        .cpu_rdata    (cpu_rdata),
        .cpu_rvalid   (cpu_rvalid),
        .upg_req      (upg_req),
        .upg_addr     (upg_addr),
        .upg_wdata    (upg_wdata),
        .upg_ack      (upg_ack),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .dbg_state    (dbg_state),
        .dbg_hold_cnt (dbg_hold_cnt)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model
    logic [31:0] ram [0:16383];

    initial begin
        for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
        ram[8]    = 32'hCAFEF00D;
        mem_rdata = 32'h0;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we == 4'h0) begin
                mem_rdata <= ram[mem_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // vector table
    typedef struct {
        string       name;
        logic        rst;
        logic        prog;
        logic        cpu_req;
        logic        cpu_we;
        logic [31:0] cpu_addr;
        logic [31:0] cpu_wdata;
        logic [3:0]  cpu_wstrb;
        logic        upg_req;
        logic [13:0] upg_addr;
        logic [31:0] upg_wdata;
        logic        e_stall;
        logic        e_rvalid;
        logic [31:0] e_rdata;
        logic        e_ack;
        logic        e_en;
        logic [3:0]  e_we;
        logic [13:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_state;
        logic [3:0]  e_hold;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string nm,
                           input logic r, input logic pm, input logic cr, input logic cw,
                           input logic [31:0] ca, input logic [31:0] cd, input logic [3:0] cs,
                           input logic ur, input logic [13:0] ua, input logic [31:0] ud,
                           input logic es, input logic erv, input logic [31:0] erd,
                           input logic eack, input logic een, input logic [3:0] ewe,
                           input logic [13:0] ea, input logic [31:0] ed,
                           input logic est, input logic [3:0] eh);
        vec_t v;
        v.name = nm; v.rst = r; v.prog = pm; v.cpu_req = cr; v.cpu_we = cw;
        v.cpu_addr = ca; v.cpu_wdata = cd; v.cpu_wstrb = cs;
        v.upg_req = ur; v.upg_addr = ua; v.upg_wdata = ud;
        v.e_stall = es; v.e_rvalid = erv; v.e_rdata = erd; v.e_ack = eack;
        v.e_en = een; v.e_we = ewe; v.e_addr = ea; v.e_wdata = ed;
        v.e_state = est; v.e_hold = eh;
        vecs.push_back(v);
    endtask

    // scoreboard compare
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // driver
    task automatic drive(input logic r, input logic pm, input logic cr, input logic cw,
                         input logic [31:0] ca, input logic [31:0] cd, input logic [3:0] cs,
                         input logic ur, input logic [13:0] ua, input logic [31:0] ud);
        @(negedge clk);
        rst = r; prog_mode = pm; cpu_req = cr; cpu_we = cw;
        cpu_addr = ca; cpu_wdata = cd; cpu_wstrb = cs;
        upg_req = ur; upg_addr = ua; upg_wdata = ud;
        #1;
    endtask

    task automatic apply_vec(input vec_t v);
        drive(v.rst, v.prog, v.cpu_req, v.cpu_we, v.cpu_addr, v.cpu_wdata, v.cpu_wstrb,
              v.upg_req, v.upg_addr, v.upg_wdata);
        chk({v.name, ".stall"},  32'(cpu_stall),    32'(v.e_stall));
        chk({v.name, ".rvalid"}, 32'(cpu_rvalid),   32'(v.e_rvalid));
        chk({v.name, ".rdata"},  cpu_rdata,         v.e_rdata);
        chk({v.name, ".ack"},    32'(upg_ack),      32'(v.e_ack));
        chk({v.name, ".en"},     32'(mem_en),       32'(v.e_en));
        chk({v.name, ".we"},     32'(mem_we),       32'(v.e_we));
        chk({v.name, ".addr"},   32'(mem_addr),     32'(v.e_addr));
        chk({v.name, ".wdata"},  mem_wdata,         v.e_wdata);
        chk({v.name, ".state"},  32'(dbg_state),    32'(v.e_state));
        chk({v.name, ".hold"},   32'(dbg_hold_cnt), 32'(v.e_hold));
    endtask

    initial begin
        logic [3:0] h1;
        logic [3:0] h2;
        int         exp_cpu;
        int         acks;
        int         cpu_cycle;
        logic       e_ack;
        logic       e_cpu;
        logic       e_upg;
        logic [3:0] e_hold;

        n_vec = 0;
        n_bad = 0;
        h1 = GUARD ? 4'd1 : 4'd0;
        h2 = GUARD ? 4'd2 : 4'd0;

        rst = 1'b1; prog_mode = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_wstrb = 4'h0;
        upg_req = 1'b0; upg_addr = 14'h0; upg_wdata = 32'h0;
        repeat (2) @(posedge clk);

        //       name         rst pm cr cw addr         wdata         strb   ur ua       ud            st rv rdata         ak en we     addr     wdata         s  hold
        add_vec("rst_idle",   1, 0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 14'h0,   32'h0,        0, 0, 32'h0,        0, 0, 4'h0,  14'h0,   32'h0,        0, 4'd0);
        add_vec("rst_stall",  1, 0, 1, 1, 32'h10,      32'hAABBCCDD, 4'h3,  1, 14'h5,   32'h5,        1, 0, 32'h0,        0, 0, 4'h0,  14'h4,   32'hAABBCCDD, 0, 4'd0);
        add_vec("st_uncont",  0, 0, 1, 1, 32'h10,      32'hAABBCCDD, 4'h3,  0, 14'h0,   32'h0,        0, 0, 32'h0,        0, 1, 4'h3,  14'h4,   32'hAABBCCDD, 0, 4'd0);
        add_vec("upg_wr",     0, 0, 0, 0, 32'h0,       32'h0,        4'h0,  1, 14'h4,   32'h12345678, 0, 0, 32'h0,        1, 1, 4'hF,  14'h4,   32'h12345678, 0, 4'd0);
        add_vec("ld_grant",   0, 0, 1, 0, 32'h10,      32'h0,        4'h0,  0, 14'h0,   32'h0,        1, 0, 32'h0,        0, 1, 4'h0,  14'h4,   32'h0,        0, 4'd0);
        add_vec("ld_data",    0, 0, 1, 0, 32'h10,      32'h0,        4'h0,  0, 14'h0,   32'h0,        0, 1, 32'h12345678, 0, 0, 4'h0,  14'h4,   32'h0,        1, 4'd0);
        add_vec("idle1",      0, 0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 14'h0,   32'h0,        0, 0, 32'h0,        0, 0, 4'h0,  14'h0,   32'h0,        0, 4'd0);
        add_vec("ld2_grant",  0, 0, 1, 0, 32'h20,      32'h0,        4'h0,  0, 14'h0,   32'h0,        1, 0, 32'h0,        0, 1, 4'h0,  14'h8,   32'h0,        0, 4'd0);
        add_vec("rdw_upg",    0, 0, 1, 0, 32'h20,      32'h0,        4'h0,  1, 14'h100, 32'h55,       0, 1, 32'hCAFEF00D, 1, 1, 4'hF,  14'h100, 32'h55,       1, 4'd0);
        add_vec("idle2",      0, 0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 14'h0,   32'h0,        0, 0, 32'h0,        0, 0, 4'h0,  14'h0,   32'h0,        0, 4'd0);
        add_vec("ld3_grant",  0, 0, 1, 0, 32'h10,      32'h0,        4'h0,  0, 14'h0,   32'h0,        1, 0, 32'h0,        0, 1, 4'h0,  14'h4,   32'h0,        0, 4'd0);
        add_vec("rst_rdw",    1, 0, 1, 0, 32'h10,      32'h0,        4'h0,  0, 14'h0,   32'h0,        1, 0, 32'h0,        0, 0, 4'h0,  14'h4,   32'h0,        1, 4'd0);
        add_vec("post_rst",   0, 0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 14'h0,   32'h0,        0, 0, 32'h0,        0, 0, 4'h0,  14'h0,   32'h0,        0, 4'd0);
        add_vec("contend1",   0, 0, 1, 1, 32'h40,      32'h11111111, 4'hF,  1, 14'h7,   32'h77,       1, 0, 32'h0,        1, 1, 4'hF,  14'h7,   32'h77,       0, 4'd0);
        add_vec("contend2",   0, 0, 1, 1, 32'h40,      32'h11111111, 4'hF,  1, 14'h7,   32'h77,       1, 0, 32'h0,        1, 1, 4'hF,  14'h7,   32'h77,       0, h1);
        add_vec("cpu_drop",   0, 0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 14'h0,   32'h0,        0, 0, 32'h0,        0, 0, 4'h0,  14'h0,   32'h0,        0, h2);
        add_vec("hold_clr",   0, 0, 0, 0, 32'h0,       32'h0,        4'h0,  0, 14'h0,   32'h0,        0, 0, 32'h0,        0, 0, 4'h0,  14'h0,   32'h0,        0, 4'd0);

        foreach (vecs[i]) apply_vec(vecs[i]);

        // Starvation: programmer writes for 8 cycles against a waiting store.
        exp_cpu   = GUARD ? 5 : 9;
        acks      = 0;
        cpu_cycle = 0;
        for (int c = 1; c <= 10; c++) begin
            drive(1'b0, 1'b0, (c <= exp_cpu), 1'b1, 32'h40, 32'hDEADBEEF, 4'h5,
                  (c <= 8), 14'(32'h200 + c), 32'(c));
            e_cpu  = (c == exp_cpu);
            e_ack  = (c <= 8) && !e_cpu;
            e_upg  = e_ack;
            e_hold = (GUARD && c <= exp_cpu) ? 4'(c - 1) : 4'd0;
            chk($sformatf("starve%0d.ack", c),   32'(upg_ack),      32'(e_ack));
            chk($sformatf("starve%0d.stall", c), 32'(cpu_stall),    32'(c < exp_cpu));
            chk($sformatf("starve%0d.en", c),    32'(mem_en),       32'(e_upg || e_cpu));
            chk($sformatf("starve%0d.we", c),    32'(mem_we),       e_upg ? 32'hF : (e_cpu ? 32'h5 : 32'h0));
            chk($sformatf("starve%0d.hold", c),  32'(dbg_hold_cnt), 32'(e_hold));
            if (upg_ack) acks++;
            if (cpu_cycle == 0 && mem_en && !upg_ack) cpu_cycle = c;
        end
        chk("starve.ack_total", 32'(acks), GUARD ? 32'd7 : 32'd8);
        chk("starve.cpu_cycle", 32'(cpu_cycle), 32'(exp_cpu));

        // Programmer mode: CPU load is ignored, port only used by programmer.
        for (int c = 0; c < 5; c++) begin
            e_upg = (c == 1) || (c == 3);
            drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0,
                  e_upg, 14'(32'h300 + c), 32'h0);
            chk($sformatf("prog%0d.stall", c),  32'(cpu_stall),    32'h1);
            chk($sformatf("prog%0d.en", c),     32'(mem_en),       32'(e_upg));
            chk($sformatf("prog%0d.we", c),     32'(mem_we),       e_upg ? 32'hF : 32'h0);
            chk($sformatf("prog%0d.ack", c),    32'(upg_ack),      32'(e_upg));
            chk($sformatf("prog%0d.rvalid", c), 32'(cpu_rvalid),   32'h0);
            chk($sformatf("prog%0d.state", c),  32'(dbg_state),    32'h0);
            chk($sformatf("prog%0d.hold", c),   32'(dbg_hold_cnt), 32'h0);
        end

        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 14'h0, 32'h0);
        chk("final.state", 32'(dbg_state), 32'h0);
        chk("final.en",    32'(mem_en),    32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_riscv_dmem_arbiter

// File: doc/riscv_dmem_arbiter.md
# riscv_dmem_arbiter

Shares the single-port data-memory block RAM between the CPU load/store path and the UART programmer write stream. Sits between the core's data-memory interface and the memory macro, below the IO bridge's address decode. Stalls the single-cycle core while the port is busy or a read is in flight. Bounds programmer priority so the core cannot starve.

## Interface
Parameters:
- `ADDR_W`, 14, word-address width of the memory macro.
- `MAX_HOLD`, 4, consecutive programmer grants allowed while the CPU waits (range 1–15).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `prog_mode`  in  1  high while the UART programmer owns the system; CPU never granted.
- `cpu_req`  in  1  CPU memory access request; held stable while `cpu_stall`=1.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_addr`  in  32  byte address; bits [ADDR_W+1:2] used.
- `cpu_wdata`  in  32  store data, already lane-aligned.
- `cpu_wstrb`  in  4  byte-lane write enables.
- `cpu_stall`  out  1  freeze PC and register writeback.
- `cpu_rdata`  out  32  load data, valid when `cpu_rvalid`=1.
- `cpu_rvalid`  out  1  one-cycle load-data strobe.
- `upg_req`  in  1  programmer word write (`upg_wen` gated by address bit 14).
- `upg_addr`  in  ADDR_W  programmer word address.
- `upg_wdata`  in  32  programmer data.
- `upg_ack`  out  1  write accepted this cycle.
- `mem_en`  out  1  macro enable.
- `mem_we`  out  4  macro byte write enables.
- `mem_addr`  out  ADDR_W  macro word address.
- `mem_wdata`  out  32  macro write data.
- `mem_rdata`  in  32  macro read data, one-cycle latency.

## Operation
- FSM states: `IDLE` and `RD_WAIT`. Also a starvation counter `hold_cnt` (4 bits) and a registered `rd_owner` flag.
- Grant decision is combinational from the registered state:
  - The programmer wins if `upg_req`=1, unless the CPU is eligible and `hold_cnt`==MAX_HOLD.
  - The CPU is eligible when `cpu_req`=1, `prog_mode`=0, and state is `IDLE`.
- CPU store grant:
  - `mem_en`=1, `mem_we`=`cpu_wstrb`, `cpu_stall`=0 in the same cycle.
  - State stays `IDLE`.
- CPU load grant:
  - `mem_en`=1, `mem_we`=0, `cpu_stall`=1, next state `RD_WAIT`.
- `RD_WAIT`:
  - `cpu_rdata`=`mem_rdata`, `cpu_rvalid`=1, `cpu_stall`=0.
  - Next state `IDLE`.
  - A programmer write may be granted in this cycle; the port is free.
  - A new CPU request is not granted in this cycle.
- Programmer grant: `mem_en`=1, `mem_we`=4'hF, `mem_addr`=`upg_addr`, `upg_ack`=1.
- `cpu_stall`=1 whenever `cpu_req`=1 and the CPU is not granted a store this cycle and state is not `RD_WAIT`.
- `hold_cnt`:
  - Increments, saturating at MAX_HOLD, on each programmer grant while an eligible CPU request is refused.
  - Clears on any CPU grant or when `cpu_req`=0.
- `prog_mode`=1: CPU requests are ignored, `cpu_stall` follows `cpu_req`, and `hold_cnt` is held at 0.
- Idle outputs: `mem_en`=0, `mem_we`=0, `mem_addr`/`mem_wdata` hold the CPU fields.

## Timing
- Reset values:
  - State `IDLE`, `hold_cnt`=0.
  - `cpu_rvalid`=0, `cpu_rdata`=0, `upg_ack`=0.
  - `mem_en`=0, `mem_we`=0, `cpu_stall`=`cpu_req`.
- Reset during `RD_WAIT` aborts the read; no `cpu_rvalid` pulse follows.
- Store latency: 0 extra cycles if uncontended.
- Load latency: 1 stall cycle; data arrives on cycle N+1 after grant cycle N.
- Simultaneous `cpu_req`+`upg_req` with `hold_cnt`<MAX_HOLD: programmer is granted, CPU is stalled.
- Worst-case CPU wait is MAX_HOLD+1 cycles.
- `upg_ack` is combinational. The programmer drops `upg_req` after the ack cycle; a request held high is a new write each cycle.

## Configuration
- `ARB_STARVE_GUARD_EN`:
  - Defined: the `hold_cnt` fairness mechanism is active as above.
  - Undefined: strict programmer priority, with no counter logic and `MAX_HOLD` unused. The CPU waits until `upg_req`=0.

## Structure
- Shared package `riscv_defs`: state encodings `ARB_IDLE`/`ARB_RD_WAIT` and the `ARB_STRB_FULL` constant (4'hF).
- Single module, no sub-modules. The starvation counter stays inline.

## Test plan
- Uncontended CPU store, addr 0x10, wstrb 4'b0011, data 0xAABBCCDD → same cycle: `mem_we`=0011, `mem_addr`=4, `cpu_stall`=0.
- CPU load from word 4 holding 0x12345678 → cycle N `cpu_stall`=1; cycle N+1 `cpu_rvalid`=1, `cpu_rdata`=0x12345678.
- `upg_req` held 8 cycles with `cpu_req` store, MAX_HOLD=4, guard enabled → 4 `upg_ack`s, CPU granted cycle 5, then programmer resumes.
- Same stimulus without `ARB_STARVE_GUARD_EN` → 8 `upg_ack`s, CPU granted cycle 9.
- `prog_mode`=1 with `cpu_req` load → `cpu_stall`=1 throughout, `mem_en` only on programmer writes.
- `rst` asserted in the `RD_WAIT` cycle → next cycle `cpu_rvalid`=0, state `IDLE`, `hold_cnt`=0.
